// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED Hamming codec: code geometry and
// classification codes.
package hamming_pkg;

    localparam logic [1:0] CLEAN  = 2'd0;
    localparam logic [1:0] SINGLE = 2'd1;
    localparam logic [1:0] DOUBLE = 2'd2;

    function automatic int calc_parity_bits(input int data_w);
        int p;
        p = 0;
        for (int i = 1; i < 31; i++) begin
            if (p == 0 && (1 << i) >= data_w + i + 1) p = i;
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Data bit i lands on the (i+1)-th non power-of-two position.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int k = 1; k <= 2 * i + 3; k++) begin
            if (!is_pow2(k)) begin
                if (cnt == i) pos = k;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity check of a received
// SECDED codeword.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int P      = calc_parity_bits(DATA_W),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic [CODE_W-1:0] code,
    output logic [P-1:0]      syn,
    output logic              q
);

    localparam int N = DATA_W + P;

    // Syndrome bit j covers every position whose index has bit j set.
    always_comb begin
        syn = '0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < P; j++) begin
                if (((k >> j) & 1) == 1) syn[j] = syn[j] ^ code[k-1];
            end
        end
        q = ^code;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready flow
// control and saturating correction statistics.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int P      = calc_parity_bits(DATA_W),
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_single,
    output logic              out_double,
    output logic [P-1:0]      out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int N = DATA_W + P;

    typedef struct packed {
        logic              vld;
        logic [P-1:0]      syn;
        logic              q;
        logic [DATA_W-1:0] dat;
    } s1_t;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] dat;
        logic [1:0]        cls;
        logic [P-1:0]      syn;
    } s2_t;

    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic [CNT_W-1:0] corr_d, corr_q;
    logic [CNT_W-1:0] uncorr_d, uncorr_q;
    logic [P-1:0]     syn;
    logic             q;
    logic [DATA_W-1:0] raw_dat;
    logic [DATA_W-1:0] fix_dat;
    logic [1:0]       cls;
    logic             advance;
    logic             out_hs;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
        .code (in_code),
        .syn  (syn),
        .q    (q)
    );

    assign advance = !s2_q.vld || out_ready;
    assign in_ready = advance;
    assign out_hs = s2_q.vld && out_ready;

    always_comb begin
        cls = DOUBLE;
        unique case (1'b1)
            (!s1_q.q && s1_q.syn == '0):           cls = CLEAN;
            (s1_q.q && int'(s1_q.syn) <= N):       cls = SINGLE;
            default:                               cls = DOUBLE;
        endcase
    end

    // Only data positions are kept; a parity-bit hit needs no repair.
    for (genvar g = 0; g < DATA_W; g++) begin : g_dat
        localparam int DP = data_pos(g);
        assign raw_dat[g] = in_code[DP-1];
        assign fix_dat[g] = s1_q.dat[g]
                          ^ (cls == SINGLE && int'(s1_q.syn) == DP);
    end

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (advance) begin
            s1_d.vld = in_valid;
            s1_d.syn = syn;
            s1_d.q   = q;
            s1_d.dat = raw_dat;
            s2_d.vld = s1_q.vld;
            s2_d.dat = fix_dat;
            s2_d.cls = cls;
            s2_d.syn = s1_q.syn;
        end
    end

    // Clear wins over a coincident increment.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (clr_cnt) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (out_hs) begin
            if (s2_q.cls == SINGLE && corr_q != '1)
                corr_d = corr_q + CNT_W'(1);
            if (s2_q.cls == DOUBLE && uncorr_q != '1)
                uncorr_d = uncorr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
        end
    end

    assign out_valid    = s2_q.vld;
    assign out_data     = s2_q.dat;
    assign out_single   = s2_q.cls == SINGLE;
    assign out_double   = s2_q.cls == DOUBLE;
    assign out_syndrome = s2_q.syn;
    assign corr_cnt     = corr_q;
    assign uncorr_cnt   = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomised and directed bench for hamming_secded_decoder against a
// position-arithmetic SECDED reference model.
module tb_hamming_secded_decoder;

    localparam int CMAX = 3;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       db;
        logic [3:0] syn;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_single;
    logic        out_double;
    logic [3:0]  out_syndrome;
    logic        clr_cnt;
    logic [1:0]  corr_cnt;
    logic [1:0]  uncorr_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   corr_m = 0;
    int   uncorr_m = 0;
    bit   stalled_prev = 0;
    bit   acc = 0;
    bit   dlv = 0;
    logic [7:0] pd;
    logic       ps, pdb;
    logic [3:0] psyn;

    hamming_secded_decoder #(.DATA_W(8), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_single   (out_single),
        .out_double   (out_double),
        .out_syndrome (out_syndrome),
        .clr_cnt      (clr_cnt),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dpos(input int i);
        int n;
        n = -1;
        for (int k = 1; k <= 12; k++) begin
            if ($countones(k) != 1) begin
                n++;
                if (n == i) return k;
            end
        end
        return 0;
    endfunction

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        int s;
        c = '0;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                c[dpos(i)-1] = 1'b1;
                s = s ^ dpos(i);
            end
        end
        for (int j = 0; j < 4; j++)
            if (((s >> j) & 1) == 1) c[(1 << j) - 1] = 1'b1;
        c[12] = ^c[11:0];
        return c;
    endfunction

    // Syndrome = XOR of the indices of all set positions.
    function automatic exp_t ref_dec(input logic [12:0] c);
        exp_t e;
        int s;
        bit q;
        logic [12:0] w;
        w = c;
        s = 0;
        for (int k = 1; k <= 12; k++)
            if (c[k-1]) s = s ^ k;
        q = ^c;
        e.s = 0;
        e.db = 0;
        if (s == 0 && !q) begin
            e.s = 0;
        end else if (q && s <= 12) begin
            e.s = 1;
            if (s != 0) w[s-1] = ~w[s-1];
        end else begin
            e.db = 1;
        end
        e.syn = 4'(s);
        for (int i = 0; i < 8; i++) e.d[i] = w[dpos(i)-1];
        return e;
    endfunction

    function automatic logic [12:0] gen();
        logic [12:0] c;
        int nf;
        c = enc(8'($urandom));
        nf = $urandom_range(0, 4);
        if (nf == 4) return 13'($urandom);
        for (int i = 0; i < nf; i++) c[$urandom_range(0, 12)] ^= 1'b1;
        return c;
    endfunction

    task automatic cycle();
        exp_t e;
        #1;
        acc = 0;
        dlv = 0;
        if (rst) begin
            sb.delete();
            corr_m = 0;
            uncorr_m = 0;
            stalled_prev = 0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            chk("corr_cnt", corr_cnt, corr_m);
            chk("uncorr_cnt", uncorr_cnt, uncorr_m);
            if (stalled_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_single", out_single, ps);
                chk("hold_double", out_double, pdb);
                chk("hold_syn", out_syndrome, psyn);
            end
            if (out_valid && sb.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else if (out_valid) begin
                e = sb[0];
                chk("data", out_data, e.d);
                chk("single", out_single, e.s);
                chk("double", out_double, e.db);
                chk("syndrome", out_syndrome, e.syn);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                dlv = 1;
                if (!clr_cnt) begin
                    if (e.s && corr_m < CMAX) corr_m++;
                    if (e.db && uncorr_m < CMAX) uncorr_m++;
                end
            end
            if (clr_cnt) begin
                corr_m = 0;
                uncorr_m = 0;
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_dec(in_code));
                acc = 1;
            end
            stalled_prev = out_valid && !out_ready;
            pd = out_data;
            ps = out_single;
            pdb = out_double;
            psyn = out_syndrome;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_dir(input logic [12:0] c, input logic [7:0] d,
                            input logic s, input logic db,
                            input logic [3:0] syn);
        in_valid = 1;
        in_code = c;
        out_ready = 1;
        cycle();
        in_valid = 0;
        chk("lat1", out_valid, 0);
        cycle();
        chk("lat2", out_valid, 1);
        chk("dir_data", out_data, d);
        chk("dir_single", out_single, s);
        chk("dir_double", out_double, db);
        chk("dir_syn", out_syndrome, syn);
        cycle();
    endtask

    initial begin
        logic [12:0] bw[4];
        int got;
        rst = 1;
        in_valid = 0;
        in_code = '0;
        out_ready = 0;
        clr_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_single", out_single, 0);
        chk("rst_double", out_double, 0);
        chk("rst_syn", out_syndrome, 0);
        chk("rst_corr", corr_cnt, 0);
        chk("rst_uncorr", uncorr_cnt, 0);
        cycle();
        rst = 0;
        #1;
        chk("rst_ready", in_ready, 1);

        send_dir(13'h0A27, 8'hA5, 0, 0, 4'd0);
        send_dir(13'h0A07, 8'hA5, 1, 0, 4'd6);
        send_dir(13'h1A27, 8'hA5, 1, 0, 4'd0);
        send_dir(13'h0A24, 8'hA5, 0, 1, 4'd3);
        send_dir(13'h0AAE, 8'hA5, 0, 1, 4'd13);
        chk("corr_after_dir", corr_cnt, 2);
        chk("uncorr_after_dir", uncorr_cnt, 2);
        send_dir(13'h0A07, 8'hA5, 1, 0, 4'd6);
        send_dir(13'h0A07, 8'hA5, 1, 0, 4'd6);
        chk("corr_sat", corr_cnt, 3);

        in_valid = 1;
        in_code = 13'h0A07;
        cycle();
        in_valid = 0;
        cycle();
        clr_cnt = 1;
        cycle();
        clr_cnt = 0;
        chk("clr_hs_corr", corr_cnt, 0);
        chk("clr_hs_uncorr", uncorr_cnt, 0);

        for (int i = 0; i < 4; i++) bw[i] = enc(8'(8'h11 * (i + 1)));
        bw[1][4] ^= 1'b1;
        got = 0;
        for (int t = 0, i = 0; t < 20 && got < 4; t++) begin
            in_valid = i < 4;
            in_code = (i < 4) ? bw[i] : '0;
            out_ready = !(t >= 3 && t < 6);
            #1;
            if (t >= 3 && t < 6) chk("bp_ready", in_ready, 0);
            cycle();
            if (acc) i++;
            if (dlv) got++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("bp_count", got, 4);

        in_valid = 1;
        in_code = enc(8'h3C);
        cycle();
        in_code = enc(8'hC3);
        cycle();
        in_valid = 0;
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_mid_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_no_stale", out_valid, 0);
        end

        in_valid = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!in_valid || acc) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_code = gen();
            end
            out_ready = $urandom_range(0, 3) != 0;
            clr_cnt = $urandom_range(0, 15) == 0;
            cycle();
        end
        in_valid = 0;
        out_ready = 1;
        clr_cnt = 0;
        for (int n = 0; n < 50 && sb.size() > 0; n++) cycle();
        chk("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
Parametrised, pipelined SECDED (single-error-correct, double-error-detect) Hamming decoder with valid/ready streaming on both sides. It generalises the 4-bit Hamming(7,4) code to any data width and adds an overall parity bit. It also keeps saturating error-statistics counters. It sits on the receive side of any link or memory path that uses our Hamming codeword layout.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- P, derived (localparam), smallest integer with 2^P >= DATA_W+P+1; P=4 for DATA_W=8.
- CODE_W, derived (localparam), DATA_W+P+1; 13 for DATA_W=8.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_code is valid.
- in_ready  out  1  decoder accepts in_code this cycle.
- in_code  in  CODE_W  received codeword.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  DATA_W  corrected payload.
- out_single  out  1  single error found and corrected (includes an error in the overall parity bit).
- out_double  out  1  uncorrectable error; out_data is the raw, uncorrected payload.
- out_syndrome  out  P  Hamming syndrome of this word.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of out_single words delivered, saturating.
- uncorr_cnt  out  CNT_W  count of out_double words delivered, saturating.

Behaviour:
- Codeword layout. Hamming position k (1..DATA_W+P) is code bit k-1. Parity bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order, d0 at position 3. Bit CODE_W-1 is overall even parity over all other bits. This matches our existing 4-bit (7,4) layout.
- Pipeline. Two register stages. Stage 1 registers the syndrome S, the overall parity Q and the raw word. Stage 2 registers the corrected data and flags. Latency is 2 cycles from input handshake to out_valid with no backpressure.
- Flow control. advance = !out_valid || out_ready. in_ready = advance. Both stages shift only when advance is high, with a global stall. An empty slot (bubble) is allowed in stage 1. Throughput is 1 word per cycle. While stalled, outputs hold stable.
- Classification:
  - S=0, Q=0: clean; single=0, double=0.
  - Q=1, S=0: error in the overall parity bit; single=1, data unchanged.
  - Q=1, 1<=S<=DATA_W+P: flip position S, then extract data; single=1.
  - Q=1, S>DATA_W+P: double=1, no correction.
  - Q=0, S!=0: double=1, no correction.
- single and double are never both 1.
- Counters:
  - On each output handshake (out_valid && out_ready), corr_cnt increments if out_single and uncorr_cnt increments if out_double.
  - Both counters saturate at all-ones.
  - clr_cnt has priority over a same-cycle increment: the result is 0, and that event is lost.
- Reset. All stage valids are 0, so out_valid=0. out_data, out_single, out_double, out_syndrome, corr_cnt and uncorr_cnt are all 0. Reset mid-stream discards in-flight words, and nothing from them appears after reset. in_ready is 1 in the cycle after reset.
- Payload registers are not reset-dependent for function, but are reset to 0 for determinism.

Decomposition:
- Package hamming_pkg holds:
  - function calc_parity_bits(DATA_W) returning P.
  - function is_pow2(k).
  - function data_pos(i), the Hamming position of data bit i.
  - classification codes CLEAN, SINGLE, DOUBLE as localparams.
- One sub-module, hamming_syndrome: combinational, in_code -> {S, Q}. The existing encoder's parity equations are reused by calling the same package functions.

Test Plan:
- Clean word, DATA_W=8: in_code=13'h0A27 -> two cycles later out_data=8'hA5, single=0, double=0, syndrome=0.
- Single data-bit error: 13'h0A07 (bit 5 flipped) -> out_data=8'hA5, single=1, syndrome=4'd6, corr_cnt increments by 1.
- Overall-parity-bit error: 13'h1A27 -> out_data=8'hA5, single=1, syndrome=0. Double error: 13'h0A24 -> double=1, syndrome=3, out_data=raw payload, uncorr_cnt increments.
- Invalid syndrome: 13'h0AAE (positions 1, 4, 8 flipped) -> S=13, Q=1 -> double=1, no correction.
- Backpressure: stream 4 words back-to-back with out_ready low for 3 cycles mid-stream -> in_ready low while stalled, held outputs stable, all 4 words delivered in order with no duplication or loss.
- Counters and reset:
  - Preload corr_cnt to all-ones with CNT_W=2 -> it stays at 3.
  - clr_cnt coincident with a single-error handshake -> corr_cnt=0.
  - rst asserted with 2 words in flight -> out_valid=0 next cycle, and no stale output afterwards.
